qsort_deadlock_reporter: RTL and testbench

//  Downstream consumer of the qsort_qsort_inst deadlock monitor's 1-bit block flag.

---
 rtl/qsort_deadlock_pkg.sv | 24 ++
 rtl/qsort_sat_counter.sv | 24 ++
 rtl/qsort_deadlock_reporter.sv | 156 +++++++++++++++
 tb/tb_qsort_deadlock_reporter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/qsort_deadlock_pkg.sv
// Shared types and default widths for the qsort deadlock reporter.
//   state_e  : reporter FSM states
//   report_t : report payload at default widths (channel mask + confirmation timestamp)
package qsort_deadlock_pkg;

    localparam int unsigned DefaultNumAxis  = 5;
    localparam int unsigned DefaultThresh   = 1024;
    localparam int unsigned DefaultPcntW    = 16;
    localparam int unsigned DefaultTsW      = 32;
    localparam int unsigned DefaultFaW      = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSuspect,
        StReport,
        StHold
    } state_e;

    typedef struct packed {
        logic [DefaultNumAxis-1:0] chan_mask;
        logic [DefaultTsW-1:0]     ts;
    } report_t;

endpackage

// File: rtl/qsort_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, synchronous clear.
// Ports:
//   clock  in   rising-edge clock
//   clr    in   synchronous clear (highest priority)
//   inc    in   increment request
//   count  out  current count
module qsort_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/qsort_deadlock_reporter.sv
// Confirms a deadlock once the monitor's block flag has stayed high for THRESHOLD
// consecutive cycles, then offers one report (channel mask + timestamp) over valid/ready.
// Episodes that end early are counted as false alarms.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   monitor_block     registered block flag from the deadlock monitor
//   axis_block_sigs   raw per-channel AXIS block flags
//   clear             acknowledge / rearm after a deadlock
//   report_ready      consumer accepts the report
//   report_valid      report payload valid
//   report_chan_mask  OR of axis_block_sigs over the confirmed episode
//   report_ts         timestamp at confirmation
//   deadlock          sticky confirmed-deadlock flag
//   false_alarm_cnt   saturating count of aborted episodes
module qsort_deadlock_reporter
    import qsort_deadlock_pkg::*;
#(
    parameter int unsigned NUM_AXIS  = DefaultNumAxis,
    parameter int unsigned THRESHOLD = DefaultThresh,
    parameter int unsigned PCNT_W    = DefaultPcntW,
    parameter int unsigned TS_W      = DefaultTsW,
    parameter int unsigned FA_W      = DefaultFaW
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                monitor_block,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic                clear,
    input  logic                report_ready,
    output logic                report_valid,
    output logic [NUM_AXIS-1:0] report_chan_mask,
    output logic [TS_W-1:0]     report_ts,
    output logic                deadlock,
    output logic [FA_W-1:0]     false_alarm_cnt
);

    // Count value seen on the cycle that samples the THRESHOLD-th consecutive high.
    localparam logic [PCNT_W-1:0] LastCnt = PCNT_W'(THRESHOLD - 1);

    state_e              state_q, state_d;
    logic [PCNT_W-1:0]   persist_q, persist_d;
    logic [NUM_AXIS-1:0] acc_q, acc_d;
    logic [NUM_AXIS-1:0] mask_q, mask_d;
    logic [TS_W-1:0]     ts_q;
    logic [TS_W-1:0]     ts_cap_q, ts_cap_d;
    logic                valid_q, valid_d;
    logic                dl_q, dl_d;
    logic                fa_inc;

    always_comb begin
        state_d   = state_q;
        persist_d = persist_q;
        acc_d     = acc_q;
        mask_d    = mask_q;
        ts_cap_d  = ts_cap_q;
        valid_d   = valid_q;
        dl_d      = dl_q;
        fa_inc    = 1'b0;

        if (clear) begin
            state_d   = StIdle;
            persist_d = '0;
            acc_d     = '0;
            mask_d    = '0;
            ts_cap_d  = '0;
            valid_d   = 1'b0;
            dl_d      = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (monitor_block) begin
                        if (THRESHOLD == 1) begin
                            state_d  = StReport;
                            dl_d     = 1'b1;
                            valid_d  = 1'b1;
                            mask_d   = axis_block_sigs;
                            ts_cap_d = ts_q;
                        end else begin
                            state_d   = StSuspect;
                            persist_d = PCNT_W'(1);
                            acc_d     = axis_block_sigs;
                        end
                    end
                end
                StSuspect: begin
                    if (monitor_block) begin
                        if (persist_q == LastCnt) begin
                            state_d   = StReport;
                            dl_d      = 1'b1;
                            valid_d   = 1'b1;
                            mask_d    = acc_q | axis_block_sigs;
                            ts_cap_d  = ts_q;
                            persist_d = '0;
                            acc_d     = '0;
                        end else begin
                            persist_d = persist_q + PCNT_W'(1);
                            acc_d     = acc_q | axis_block_sigs;
                        end
                    end else begin
                        state_d   = StIdle;
                        persist_d = '0;
                        acc_d     = '0;
                        fa_inc    = 1'b1;
                    end
                end
                StReport: begin
                    if (report_ready) begin
                        state_d = StHold;
                        valid_d = 1'b0;
                    end
                end
                StHold: begin
                    // Waits for clear; inputs ignored.
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            persist_q <= '0;
            acc_q     <= '0;
            mask_q    <= '0;
            ts_cap_q  <= '0;
            valid_q   <= 1'b0;
            dl_q      <= 1'b0;
            ts_q      <= '0;
        end else begin
            state_q   <= state_d;
            persist_q <= persist_d;
            acc_q     <= acc_d;
            mask_q    <= mask_d;
            ts_cap_q  <= ts_cap_d;
            valid_q   <= valid_d;
            dl_q      <= dl_d;
            ts_q      <= ts_q + TS_W'(1);
        end
    end

    qsort_sat_counter #(
        .W(FA_W)
    ) u_fa_cnt (
        .clock(clock),
        .clr  (reset),
        .inc  (fa_inc),
        .count(false_alarm_cnt)
    );

    assign report_valid     = valid_q;
    assign report_chan_mask = mask_q;
    assign report_ts        = ts_cap_q;
    assign deadlock         = dl_q;

endmodule

// File: tb/tb_qsort_deadlock_reporter.sv
// Self-checking bench for qsort_deadlock_reporter.
// dut_a: THRESHOLD=8, FA_W=16; dut_c: same stimulus, FA_W=2 (saturation);
// dut_b: THRESHOLD=1 with its own stimulus.
module tb_qsort_deadlock_reporter;

    typedef struct {
        logic        blk;
        logic [4:0]  sigs;
        logic        clr;
        logic        rdy;
        logic        valid;
        logic        dl;
        logic [4:0]  mask;
        logic [31:0] ts;
        logic [15:0] fa;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        blk, clr, rdy;
    logic [4:0]  sigs;
    logic        b_blk, b_clr, b_rdy;
    logic [4:0]  b_sigs;

    logic        a_valid, a_dl;
    logic [4:0]  a_mask;
    logic [31:0] a_ts;
    logic [15:0] a_fa;
    logic        c_valid, c_dl;
    logic [4:0]  c_mask;
    logic [31:0] c_ts;
    logic [1:0]  c_fa;
    logic        b_valid, b_dl;
    logic [4:0]  b_mask;
    logic [31:0] b_ts;
    logic [15:0] b_fa;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clock = ~clock;

    qsort_deadlock_reporter #(.THRESHOLD(8)) dut_a (
        .clock(clock), .reset(reset), .monitor_block(blk), .axis_block_sigs(sigs),
        .clear(clr), .report_ready(rdy), .report_valid(a_valid),
        .report_chan_mask(a_mask), .report_ts(a_ts), .deadlock(a_dl),
        .false_alarm_cnt(a_fa)
    );

    qsort_deadlock_reporter #(.THRESHOLD(8), .FA_W(2)) dut_c (
        .clock(clock), .reset(reset), .monitor_block(blk), .axis_block_sigs(sigs),
        .clear(clr), .report_ready(rdy), .report_valid(c_valid),
        .report_chan_mask(c_mask), .report_ts(c_ts), .deadlock(c_dl),
        .false_alarm_cnt(c_fa)
    );

    qsort_deadlock_reporter #(.THRESHOLD(1)) dut_b (
        .clock(clock), .reset(reset), .monitor_block(b_blk), .axis_block_sigs(b_sigs),
        .clear(b_clr), .report_ready(b_rdy), .report_valid(b_valid),
        .report_chan_mask(b_mask), .report_ts(b_ts), .deadlock(b_dl),
        .false_alarm_cnt(b_fa)
    );

    function automatic void add(input logic bk, input logic [4:0] s, input logic cl,
                                input logic rd, input logic v, input logic d,
                                input logic [4:0] m, input logic [31:0] t,
                                input logic [15:0] f);
        vec_t x;
        x.blk = bk; x.sigs = s; x.clr = cl; x.rdy = rd;
        x.valid = v; x.dl = d; x.mask = m; x.ts = t; x.fa = f;
        vecs.push_back(x);
    endfunction

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        if (reset) cyc = 0;
        else cyc++;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    // Payload is unspecified after the handshake (HOLD), so it is skipped there.
    task automatic cmp_vec(input string nm, input vec_t e);
        logic pay_ok;
        checks++;
        pay_ok = (e.dl && !e.valid) ? 1'b1 : (a_mask === e.mask && a_ts === e.ts);
        if (a_valid !== e.valid || a_dl !== e.dl || a_fa !== e.fa || !pay_ok ||
            c_valid !== e.valid || c_dl !== e.dl) begin
            errors++;
            $display("FAIL %s: got valid=%b dl=%b mask=%b ts=%0d fa=%0d (c valid=%b dl=%b), expected valid=%b dl=%b mask=%b ts=%0d fa=%0d",
                     nm, a_valid, a_dl, a_mask, a_ts, a_fa, c_valid, c_dl,
                     e.valid, e.dl, e.mask, e.ts, e.fa);
        end
    endtask

    initial begin
        vec_t e;
        int   t;

        // Test 1: 7 high then low -> false alarm (indices 0..7), idle to index 99.
        for (int i = 0; i < 7; i++) add(1, 5'b0, 0, 0, 0, 0, 5'b0, 0, 0);
        add(0, 5'b0, 0, 0, 0, 0, 5'b0, 0, 1);
        for (int i = 8; i < 100; i++) add(0, 5'b0, 0, 0, 0, 0, 5'b0, 0, 1);
        // Test 2: 8 high from ts=100; ch1 on cycles 1-2, ch3 on cycle 8.
        add(1, 5'b00010, 0, 0, 0, 0, 5'b0, 0, 1);
        add(1, 5'b00010, 0, 0, 0, 0, 5'b0, 0, 1);
        for (int i = 102; i < 107; i++) add(1, 5'b0, 0, 0, 0, 0, 5'b0, 0, 1);
        add(1, 5'b01000, 0, 0, 1, 1, 5'b01010, 107, 1);
        // Test 3: backpressure for 20 cycles, block toggling ignored.
        for (int i = 0; i < 20; i++)
            add(logic'(i % 2), 5'(i), 0, 0, 1, 1, 5'b01010, 107, 1);
        add(0, 5'b0, 0, 1, 0, 1, 5'b0, 0, 1);
        for (int i = 0; i < 10; i++)
            add(logic'(i % 2), 5'b11111, 0, logic'((i / 2) % 2), 0, 1, 5'b0, 0, 1);
        add(0, 5'b0, 1, 0, 0, 0, 5'b0, 0, 1);
        // Test 4: report, then clear+ready together, then a second report.
        for (int i = 140; i < 147; i++) add(1, 5'b00001, 0, 0, 0, 0, 5'b0, 0, 1);
        add(1, 5'b00001, 0, 0, 1, 1, 5'b00001, 147, 1);
        add(1, 5'b11111, 1, 1, 0, 0, 5'b0, 0, 1);
        for (int i = 149; i < 156; i++) add(1, 5'b10000, 0, 0, 0, 0, 5'b0, 0, 1);
        add(1, 5'b10000, 0, 0, 1, 1, 5'b10000, 156, 1);
        add(0, 5'b0, 0, 1, 0, 1, 5'b0, 0, 1);
        add(0, 5'b0, 1, 0, 0, 0, 5'b0, 0, 1);
        // Clear during SUSPECT with block low is not a false alarm.
        add(1, 5'b00100, 0, 0, 0, 0, 5'b0, 0, 1);
        add(1, 5'b00100, 0, 0, 0, 0, 5'b0, 0, 1);
        add(0, 5'b0, 1, 0, 0, 0, 5'b0, 0, 1);
        add(0, 5'b0, 0, 0, 0, 0, 5'b0, 0, 1);
        // Four more aborted episodes -> 5 total.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) add(1, 5'b00011, 0, 0, 0, 0, 5'b0, 0, 16'(1 + k));
            add(0, 5'b0, 0, 0, 0, 0, 5'b0, 0, 16'(2 + k));
        end

        reset = 1'b1; blk = 0; sigs = '0; clr = 0; rdy = 0;
        b_blk = 0; b_sigs = '0; b_clr = 0; b_rdy = 0;
        step();
        step();
        check("reset_valid", 32'(a_valid), 0);
        check("reset_deadlock", 32'(a_dl), 0);
        check("reset_fa", 32'(a_fa), 0);
        reset = 1'b0;

        // Scoreboard: expectation queued on drive, popped once the edge has happened.
        foreach (vecs[i]) begin
            blk = vecs[i].blk; sigs = vecs[i].sigs; clr = vecs[i].clr; rdy = vecs[i].rdy;
            exp_q.push_back(vecs[i]);
            step();
            e = exp_q.pop_front();
            cmp_vec($sformatf("vec%0d", i), e);
        end
        blk = 0; sigs = '0; clr = 0; rdy = 0;
        check("fa_saturated_w2", 32'(c_fa), 3);
        check("fa_count_w16", 32'(a_fa), 5);

        // THRESHOLD=1 instance.
        check("t1_idle_deadlock", 32'(b_dl), 0);
        b_blk = 1; b_clr = 1;
        step();
        check("t1_clear_wins", 32'(b_dl), 0);
        b_clr = 0; b_sigs = 5'b00100;
        t = cyc;
        step();
        b_blk = 0; b_sigs = '0;
        check("t1_valid", 32'(b_valid), 1);
        check("t1_deadlock", 32'(b_dl), 1);
        check("t1_mask", 32'(b_mask), 32'b00100);
        check("t1_ts", b_ts, 32'(t));
        b_rdy = 1;
        step();
        b_rdy = 0;
        check("t1_valid_drop", 32'(b_valid), 0);
        check("t1_deadlock_hold", 32'(b_dl), 1);

        // Reset in SUSPECT with persist_cnt=5 aborts the episode.
        blk = 1; sigs = 5'b00001;
        for (int i = 0; i < 5; i++) step();
        check("pre_reset_deadlock", 32'(a_dl), 0);
        reset = 1;
        step();
        check("rst_valid", 32'(a_valid), 0);
        check("rst_deadlock", 32'(a_dl), 0);
        check("rst_mask", 32'(a_mask), 0);
        check("rst_ts", a_ts, 0);
        check("rst_fa", 32'(a_fa), 0);
        check("rst_fa_w2", 32'(c_fa), 0);
        check("rst_t1_deadlock", 32'(b_dl), 0);
        reset = 0;
        for (int i = 0; i < 7; i++) step();
        check("post_reset_7", 32'(a_dl), 0);
        t = cyc;
        step();
        check("post_reset_8", 32'(a_dl), 1);
        check("post_reset_ts", a_ts, 32'(t));
        check("post_reset_mask", 32'(a_mask), 32'b00001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
